// File: rtl/wallace_multiplier_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wallace_multiplier_if : operand/result bus for the 8x8 multiplier     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface wallace_multiplier_if;
    logic        in_valid;
    logic [8:1]  a;
    logic [8:1]  b;
    logic        out_valid;
    logic [18:1] product;

    modport master (output in_valid, a, b, input  out_valid, product);
    modport slave  (input  in_valid, a, b, output out_valid, product);
endinterface
`default_nettype wire

// File: rtl/wallace_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wallace_multiplier : 8x8 unsigned Wallace-tree multiplier, 2-cycle    |
// | latency, one product per clock. Revision : 1.0                        |
// +-----------------------------------------------------------------------+

module full_adder (
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
endmodule

module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

// One 3:2 compression of three 16-bit rows. The product never reaches 2^16,
// so a carry leaving bit 15 is always zero and is not generated.
module wallace_csa16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [15:0] z_i,
    output logic [15:0] s_o,
    output logic [15:0] c_o
);
    assign c_o[0] = 1'b0;
    assign s_o[15] = x_i[15] ^ y_i[15] ^ z_i[15];

    generate
        for (genvar k = 0; k < 15; k++) begin : g_bit
            full_adder u_fa (
                .x_i (x_i[k]),
                .y_i (y_i[k]),
                .z_i (z_i[k]),
                .s_o (s_o[k]),
                .c_o (c_o[k+1])
            );
        end
    endgenerate
endmodule

module wallace_multiplier (
    input  logic                     clk,
    input  logic                     rst_n,
    wallace_multiplier_if.slave      bus
);
    logic [8:1]  a_q;
    logic [8:1]  b_q;
    logic        v_q;
    logic [18:1] product_q;
    logic [18:1] product_d;
    logic        out_valid_q;

    logic [15:0] w_pp [8];
    logic [15:0] w_l1 [6];
    logic [15:0] w_l2 [4];
    logic [15:0] w_l3 [3];
    logic [15:0] w_l4 [2];
    logic [15:0] w_sum;
    logic [15:1] w_cy;

    // Row j holds a_q gated by b_q[j+1], pre-shifted to weight 2^j.
    generate
        for (genvar j = 0; j < 8; j++) begin : g_pp
            assign w_pp[j] = {8'd0, a_q & {8{b_q[j+1]}}} << j;
        end
    endgenerate

    // 8 -> 6 rows
    wallace_csa16 u_l1_0 (.x_i(w_pp[0]), .y_i(w_pp[1]), .z_i(w_pp[2]), .s_o(w_l1[0]), .c_o(w_l1[1]));
    wallace_csa16 u_l1_1 (.x_i(w_pp[3]), .y_i(w_pp[4]), .z_i(w_pp[5]), .s_o(w_l1[2]), .c_o(w_l1[3]));
    assign w_l1[4] = w_pp[6];
    assign w_l1[5] = w_pp[7];

    // 6 -> 4 rows
    wallace_csa16 u_l2_0 (.x_i(w_l1[0]), .y_i(w_l1[1]), .z_i(w_l1[2]), .s_o(w_l2[0]), .c_o(w_l2[1]));
    wallace_csa16 u_l2_1 (.x_i(w_l1[3]), .y_i(w_l1[4]), .z_i(w_l1[5]), .s_o(w_l2[2]), .c_o(w_l2[3]));

    // 4 -> 3 -> 2 rows
    wallace_csa16 u_l3_0 (.x_i(w_l2[0]), .y_i(w_l2[1]), .z_i(w_l2[2]), .s_o(w_l3[0]), .c_o(w_l3[1]));
    assign w_l3[2] = w_l2[3];
    wallace_csa16 u_l4_0 (.x_i(w_l3[0]), .y_i(w_l3[1]), .z_i(w_l3[2]), .s_o(w_l4[0]), .c_o(w_l4[1]));

    // Final ripple adder; the carry row's LSB is always zero so bit 0 needs only a half adder.
    half_adder u_rca_ha (
        .x_i (w_l4[0][0]),
        .y_i (w_l4[1][0]),
        .s_o (w_sum[0]),
        .c_o (w_cy[1])
    );

    generate
        for (genvar k = 1; k < 15; k++) begin : g_rca
            full_adder u_fa (
                .x_i (w_l4[0][k]),
                .y_i (w_l4[1][k]),
                .z_i (w_cy[k]),
                .s_o (w_sum[k]),
                .c_o (w_cy[k+1])
            );
        end
    endgenerate

    assign w_sum[15] = w_l4[0][15] ^ w_l4[1][15] ^ w_cy[15];
    assign product_d = {2'b00, w_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            v_q         <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= bus.a;
            b_q         <= bus.b;
            v_q         <= bus.in_valid;
            product_q   <= product_d;
            out_valid_q <= v_q;
        end
    end

    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_wallace_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_wallace_multiplier : directed and exhaustive bench for the 8x8     |
// | Wallace multiplier. Revision : 1.0                                    |
// +-----------------------------------------------------------------------+
module tb_wallace_multiplier;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Expectations for the operands driven one and two cycles ago.
    logic        pv0, pv1;
    logic [17:0] pe0, pe1;

    wallace_multiplier_if bus ();

    wallace_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%05h) want=%0d (0x%05h)", tag, got, got, exp, exp);
        end
    endtask

    // At each falling edge: check what was driven two cycles ago, then drive new operands.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [17:0] e, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, {17'd0, bus.out_valid}, {17'd0, pv1});
        if (pv1) chk({tag, "_prod"}, bus.product, pe1);
        pv1 = pv0;
        pe1 = pe0;
        pv0 = v;
        pe0 = e;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic flush(input string tag);
        step(1'b0, 8'd0, 8'd0, 18'd0, tag);
        step(1'b0, 8'd0, 8'd0, 18'd0, tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pv0 = 1'b0; pv1 = 1'b0; pe0 = '0; pe1 = '0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;

        #8;
        chk("reset_prod",  bus.product, 18'd0);
        chk("reset_valid", {17'd0, bus.out_valid}, 18'd0);
        #4 rst_n = 1'b1;

        // single operation and corners
        step(1'b1, 8'd119, 8'd165, 18'd19635, "basic");
        flush("basic");
        step(1'b1, 8'hFF, 8'hFF, 18'h0FE01, "maxmax");
        flush("maxmax");
        step(1'b1, 8'h00, 8'hA5, 18'd0, "zero");
        flush("zero");
        step(1'b1, 8'h01, 8'h5A, 18'h0005A, "one");
        flush("one");

        // back-to-back stream
        step(1'b1, 8'd119, 8'd165, 18'd19635, "stream");
        step(1'b1, 8'd255, 8'd255, 18'd65025, "stream");
        step(1'b1, 8'h80,  8'h02,  18'd256,   "stream");
        step(1'b1, 8'd3,   8'd5,   18'd15,    "stream");
        flush("stream");

        // valid gaps: the middle pair must not raise out_valid
        step(1'b1, 8'd10, 8'd20, 18'd200, "gap");
        step(1'b0, 8'd7,  8'd9,  18'd0,   "gap");
        step(1'b1, 8'd12, 8'd12, 18'd144, "gap");
        flush("gap");

        // asynchronous reset with two operations in flight
        step(1'b1, 8'd200, 8'd100, 18'd20000, "inflight");
        step(1'b1, 8'd50,  8'd60,  18'd3000,  "inflight");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_prod",  bus.product, 18'd0);
        chk("async_rst_valid", {17'd0, bus.out_valid}, 18'd0);
        bus.in_valid = 1'b0;
        pv0 = 1'b0; pv1 = 1'b0;
        #4 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 8'd33, 8'd44, 18'd0, "post_rst");

        // exhaustive stream against a behavioural model
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] ea, eb;
            ea = i[15:8];
            eb = i[7:0];
            step(1'b1, ea, eb, 18'(ea * eb), "exh");
        end
        flush("exh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wallace_multiplier.md
# wallace_multiplier

Unsigned 8×8 multiplier built as a Wallace-tree partial-product reducer followed by a final carry-propagate adder. It is registered at input and output, giving a fixed two-cycle latency with full throughput of one product per clock. It serves as the arithmetic core for datapath blocks that need a 16-bit product. The output is presented on an 18-bit bus, zero-extended.

## Interface
Parameters: none. Widths are fixed at 8×8 → 18.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  qualifies a and b in the current cycle
- a  input  8  multiplicand, unsigned, bit 8 is the MSB (port range [8:1])
- b  input  8  multiplier, unsigned, range [8:1]
- out_valid  output  1  product holds a valid result
- product  output  18  a×b, unsigned, range [18:1]; bits 18:17 always 0

## Operation
- Stage 0, input registers: on each rising clk, a_r ← a, b_r ← b, v_r ← in_valid.
- Partial products: 64 AND terms pp[i][j] = a_r[i] & b_r[j], weighted 2^(i+j-2) in 1-based indexing.
- Wallace reduction: columns are reduced with full adders (3:2) and half adders (2:2) in successive layers, in the order 8 rows → 6 → 4 → 3 → 2.
  - Each layer groups every column's bits in threes.
  - A leftover pair goes to a half adder only when needed to meet the layer's row target; otherwise it passes through.
  - Carries move to the next column in the next layer.
- Final adder: the two remaining rows are summed by a 16-bit ripple-carry adder built from the same FA/HA cells. The carry out of bit 16 is provably 0.
- Stage 1, output register: on each rising clk, product ← {2'b00, sum[16:1]}, out_valid ← v_r.
- Arithmetic: exact unsigned product. The maximum is 255×255 = 65025 (0xFE01), so there is no overflow or truncation. Signed operands are not supported.
- Data registers capture every cycle regardless of in_valid. When out_valid = 0, product reflects whatever was sampled and must not be used.
- No behavioural `*` operator is used anywhere. The tree is structural, with explicit half_adder and full_adder cells; submodules are permitted.

## Timing
- Latency: operands sampled at edge N appear on product at edge N+1 (product registered at N+1, visible after it). Count: in_valid high before edge N → out_valid high after edge N+1, i.e. 2 edges.
- Throughput: one new operand pair per clock, with no stalls and no backpressure.
- Reset:
  - When rst_n falls, a_r, b_r, v_r, product and out_valid all clear to 0 immediately, independent of clk.
  - Operations in flight are discarded.
  - After rst_n rises, the first capture occurs at the next rising edge.
  - out_valid stays 0 until a valid operand has passed both stages.
- Reset release coinciding with a clock edge: the design tolerates it. The first sample may be taken at that edge or at the next one. The bench must not depend on which.
- Critical path: input register → AND → 4 reduction layers → 16-bit ripple → output register.

## Test plan
- a=8'b01110111 (119), b=8'b10100101 (165), in_valid=1 → two edges later product=18'b00_0100_1100_1011_0011 (19635, 0x4CB3), out_valid=1.
- Corners:
  - a=0xFF, b=0xFF → product=0x0FE01 (65025); bits 18:17=0.
  - a=0, b=0xA5 → 0.
  - a=1, b=0x5A → 0x5A.
- Streaming: apply (119,165), (255,255), (0x80,0x02), (3,5) on consecutive cycles → products 19635, 65025, 256, 15 appear on consecutive cycles starting 2 edges after the first, with out_valid high throughout.
- Valid gaps: in_valid pattern 1,0,1 → out_valid pattern 1,0,1 delayed by 2 edges.
- Reset mid-operation: assert rst_n=0 between edges while two operations are in flight → product=0 and out_valid=0 immediately, asynchronously. After release with in_valid=0, out_valid stays 0.
- Exhaustive: all 65536 (a,b) pairs streamed back-to-back → product == a*b, checked against a behavioural model.
